// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: pointer-addressed register file behind the i2c_target byte stream,
// with auto-increment bursts, fabric-fed read-only registers and per-register write strobes.
module i2c_reg_bank #(
   parameter int                        NUM_REGS    = 8,
   parameter logic [NUM_REGS-1:0]       RO_MASK     = '0,
   parameter logic [NUM_REGS*8-1:0]     RESET_VALUE = '0,
   parameter int                        DEBUG_REG   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i2c_start_i,
   input  logic [7:0]            i2c_rx_byte_data_i,
   input  logic                  i2c_rx_byte_valid_i,
   input  logic                  i2c_tx_byte_req_i,
   output logic [7:0]            i2c_tx_byte_data_o,
   output logic                  i2c_tx_byte_valid_o,
   input  logic [NUM_REGS*8-1:0] status_i,
   output logic [NUM_REGS*8-1:0] regs_o,
   output logic [NUM_REGS-1:0]   reg_wr_o,
   output logic [7:0]            debug_o
);
   localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   typedef enum logic [1:0] {IDLE, PTR, DATA} state_t;
   state_t                     state;
   logic [PTR_W-1:0]           ptr;
   logic [NUM_REGS-1:0][7:0]   regs_q;
   assign regs_o  = regs_q;
   assign debug_o = regs_q[DEBUG_REG];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= IDLE;
         ptr                 <= '0;
         i2c_tx_byte_data_o  <= '0;
         i2c_tx_byte_valid_o <= 1'b0;
         reg_wr_o            <= '0;
         regs_q              <= RESET_VALUE;
      end else begin
         i2c_tx_byte_valid_o <= 1'b0;
         reg_wr_o            <= '0;
         // start outranks rx, which outranks tx; the losing event is dropped
         if (i2c_start_i) begin
            state <= PTR;
         end else if (i2c_rx_byte_valid_i) begin
            if (state == PTR) begin
               ptr   <= i2c_rx_byte_data_i[PTR_W-1:0];
               state <= DATA;
            end else if (state == DATA) begin
               if (!RO_MASK[ptr]) begin
                  regs_q[ptr]   <= i2c_rx_byte_data_i;
                  reg_wr_o[ptr] <= 1'b1;
               end
               ptr <= ptr + 1'b1;
            end
         end else if (i2c_tx_byte_req_i) begin
            i2c_tx_byte_data_o  <= regs_q[ptr];
            i2c_tx_byte_valid_o <= 1'b1;
            ptr                 <= ptr + 1'b1;
            if (state == PTR) state <= DATA;
         end
         for (int i = 0; i < NUM_REGS; i++)
            if (RO_MASK[i]) regs_q[i] <= status_i[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: directed and random byte-stream traffic against a queue-based
// scoreboard; a negedge monitor checks every tx byte and write strobe the DUT emits.
module tb_i2c_reg_bank;
   localparam int               N   = 8;
   localparam logic [N-1:0]     RO  = 8'h04;
   localparam logic [N*8-1:0]   RV  = 64'h1716151413121110;
   logic clk = 0, rst_n = 0, start = 0, rx_valid = 0, req = 0;
   logic [7:0] rx_data = 0;
   logic [N*8-1:0] status = 64'h0;
   logic [7:0] tx_data, debug;
   logic tx_valid;
   logic [N*8-1:0] regs;
   logic [N-1:0] reg_wr;
   int errors = 0, checks = 0;
   logic [7:0] m_regs [N];
   int m_ptr, m_st;
   logic [7:0] exp_tx [$];
   int exp_wr_idx [$];
   logic [7:0] exp_wr_val [$];

   i2c_reg_bank #(.NUM_REGS(N), .RO_MASK(RO), .RESET_VALUE(RV), .DEBUG_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .i2c_start_i(start), .i2c_rx_byte_data_i(rx_data),
      .i2c_rx_byte_valid_i(rx_valid), .i2c_tx_byte_req_i(req),
      .i2c_tx_byte_data_o(tx_data), .i2c_tx_byte_valid_o(tx_valid),
      .status_i(status), .regs_o(regs), .reg_wr_o(reg_wr), .debug_o(debug));

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (tx_valid) begin
         if (exp_tx.size() == 0) chk("tx_unexpected", {56'h0, tx_data}, 64'hx_dead);
         else chk("tx_data", {56'h0, tx_data}, {56'h0, exp_tx.pop_front()});
      end
      if (reg_wr != 0) begin
         if (exp_wr_idx.size() == 0) chk("wr_unexpected", {56'h0, reg_wr}, 64'h0);
         else begin
            automatic int idx = exp_wr_idx.pop_front();
            chk("reg_wr", {56'h0, reg_wr}, 64'h1 << idx);
            chk("wr_val", {56'h0, regs[8*idx +: 8]}, {56'h0, exp_wr_val.pop_front()});
         end
      end
   end

   function automatic logic [N*8-1:0] flat();
      logic [N*8-1:0] f;
      for (int i = 0; i < N; i++) f[8*i +: 8] = m_regs[i];
      return f;
   endfunction

   task automatic check_regs(string name);
      chk(name, regs, flat());
      chk({name, "_dbg"}, {56'h0, debug}, {56'h0, m_regs[0]});
   endtask

   task automatic do_reset();
      rst_n = 0;
      @(posedge clk);
      for (int i = 0; i < N; i++) m_regs[i] = RV[8*i +: 8];
      m_ptr = 0;
      m_st = 0;
      #1;
      check_regs("reset_regs");
      chk("reset_valid", {63'h0, tx_valid}, 64'h0);
      chk("reset_data", {56'h0, tx_data}, 64'h0);
      chk("reset_wr", {56'h0, reg_wr}, 64'h0);
      rst_n = 1;
   endtask

   // Model: states 0=idle, 1=expect pointer, 2=data; effects follow the event priority rules.
   task automatic cyc(bit s, bit rv, logic [7:0] d, bit rq);
      start = s; rx_valid = rv; rx_data = d; req = rq;
      @(posedge clk);
      if (s) m_st = 1;
      else if (rv) begin
         if (m_st == 1) begin
            m_ptr = d % N;
            m_st = 2;
         end else if (m_st == 2) begin
            if (!RO[m_ptr]) begin
               m_regs[m_ptr] = d;
               exp_wr_idx.push_back(m_ptr);
               exp_wr_val.push_back(d);
            end
            m_ptr = (m_ptr + 1) % N;
         end
      end else if (rq) begin
         exp_tx.push_back(m_regs[m_ptr]);
         m_ptr = (m_ptr + 1) % N;
         if (m_st == 1) m_st = 2;
      end
      for (int i = 0; i < N; i++) if (RO[i]) m_regs[i] = status[8*i +: 8];
      #1;
      start = 0; rx_valid = 0; req = 0;
   endtask

   initial begin
      logic [7:0] burst [6];
      burst = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      status[23:16] = 8'h5A;
      do_reset();
      cyc(0, 0, 0, 0);
      check_regs("ro_track");
      cyc(1, 0, 0, 0);
      cyc(0, 1, 8'h03, 0);
      foreach (burst[i]) cyc(0, 1, burst[i], 0);
      check_regs("burst_wrap");
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 8'h06, 0);
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 8'h02, 0);
      cyc(0, 1, 8'h99, 0);
      check_regs("ro_nowrite");
      status[23:16] = 8'h33;
      cyc(0, 0, 0, 0);
      check_regs("ro_update");
      cyc(0, 0, 0, 1);
      do_reset();
      cyc(0, 1, 8'h44, 0);
      cyc(1, 1, 8'h41, 0);
      check_regs("idle_ignore");
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 8'h00, 0);
      cyc(0, 1, 8'h01, 0);
      cyc(0, 1, 8'h02, 0);
      do_reset();
      cyc(0, 1, 8'h77, 0);
      check_regs("post_reset_idle");
      cyc(0, 0, 0, 1);
      for (int k = 0; k < 600; k++) begin
         automatic int r = $urandom_range(0, 99);
         automatic logic [7:0] d = 8'($urandom);
         if ($urandom_range(0, 15) == 0) status = {$urandom, $urandom};
         if (r < 6) cyc(1, $urandom_range(0, 1) == 1, d, $urandom_range(0, 1) == 1);
         else if (r < 45) cyc(0, 1, d, 0);
         else if (r < 80) cyc(0, 0, 0, 1);
         else if (r < 88) cyc(0, 1, d, 1);
         else cyc(0, 0, 0, 0);
         if (k % 16 == 15) check_regs("rand_regs");
         if (k == 300) do_reset();
      end
      repeat (3) cyc(0, 0, 0, 0);
      chk("tx_queue_empty", exp_tx.size(), 0);
      chk("wr_queue_empty", exp_wr_idx.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
